// File: rtl/apb_regfile_slave.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_regfile_slave
//   APB completer holding a small register file with programmable wait
//   states. Locations 0 .. 2**ADDR_W-2 are read/write registers; the top
//   location is a read-only count of completed register writes (wraps
//   modulo 2**DATA_W). All outputs are registered; there is no
//   combinational path from any input to any output.
//
// Parameters
//   ADDR_W       address width (2**ADDR_W locations, top one read-only)
//   DATA_W       register / bus data width
//   WAIT_CYCLES  pready-low cycles inserted in each access phase (0 = none)
//
// Ports
//   pclk          in   clock, everything on the rising edge
//   preset        in   synchronous active-high reset
//   pselx         in   slave select
//   penable       in   access phase marker
//   pwrite        in   1 = write, 0 = read
//   paddr         in   [ADDR_W-1:0] address
//   pwdata        in   [DATA_W-1:0] write data
//   prdata        out  [DATA_W-1:0] read data, non-zero only with pready
//   pready        out  transfer complete, high for exactly one cycle
//   pslave_error  out  error response, only ever high with pready
//
// Build option
//   APB_REGFILE_SLAVE_ERR_EN  when defined, a write to the top (read-only)
//   address returns pslave_error=1. When undefined, such writes are
//   silently dropped and pslave_error is constant 0.
// ---------------------------------------------------------------------------
module apb_regfile_slave #(
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              pselx,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslave_error
);

  localparam int NREG  = (2 ** ADDR_W) - 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};
  // Counter reload value; only used when WAIT_CYCLES > 0.
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_READY = 2'b10
  } state_e;

  state_e              state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic                write_q,  write_d;
  logic [DATA_W-1:0]   mem_q [NREG];
  logic [DATA_W-1:0]   mem_d [NREG];
  logic [DATA_W-1:0]   wcount_q, wcount_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                perr_q,   perr_d;

  // Next-state, register-file update and response computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    mem_d    = mem_q;
    wcount_d = wcount_q;

    case (state_q)
      ST_IDLE: begin
        // Only a genuine setup phase starts a transfer; penable without a
        // preceding setup is ignored.
        if (pselx && !penable) begin
          addr_d  = paddr;
          wdata_d = pwdata;
          write_d = pwrite;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        // Deselect during the wait abandons the transfer with no side effects.
        if (!pselx) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_READY: begin
        // The transfer completes at this edge, so the write commits here.
        state_d = ST_IDLE;
        if (write_q && (addr_q != TOP_ADDR)) begin
          for (int i = 0; i < NREG; i++) begin
            mem_d[i] = (addr_q == ADDR_W'(i)) ? wdata_q : mem_q[i];
          end
          wcount_d = wcount_q + DATA_W'(1);
        end else begin
          wcount_d = wcount_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    // Response registers are loaded on the edge that enters READY. addr_d /
    // write_d already hold the transfer's latched values at that point, both
    // for the zero-wait path (fresh from the bus) and the wait path (held).
    pready_d = 1'b0;
    prdata_d = {DATA_W{1'b0}};
    perr_d   = 1'b0;
    if (state_d == ST_READY) begin
      pready_d = 1'b1;
      if (!write_d) begin
        if (addr_d == TOP_ADDR) begin
          prdata_d = wcount_q;
        end else begin
          for (int i = 0; i < NREG; i++) begin
            prdata_d = (addr_d == ADDR_W'(i)) ? mem_q[i] : prdata_d;
          end
        end
      end else begin
        prdata_d = {DATA_W{1'b0}};
      end
`ifdef APB_REGFILE_SLAVE_ERR_EN
      perr_d = write_d && (addr_d == TOP_ADDR);
`else
      perr_d = 1'b0;
`endif
    end else begin
      pready_d = 1'b0;
    end
  end

  // State, storage and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      write_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      wcount_q <= {DATA_W{1'b0}};
      prdata_q <= {DATA_W{1'b0}};
      pready_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wcount_q <= wcount_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
      perr_q   <= perr_d;
    end
  end

  assign prdata       = prdata_q;
  assign pready       = pready_q;
  assign pslave_error = perr_q;

endmodule
